// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared definitions for the MIPS monocycle core front end.
//                Fetch state encoding and fault-cause codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Fetch sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_e;

    // Fault cause codes reported on fault_cause
    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_BUS      = 2'b01;
    localparam logic [1:0] FC_MISALIGN = 2'b10;
    localparam logic [1:0] FC_TIMEOUT  = 2'b11;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/fetch_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_watchdog
//  Description : Clear/enable cycle counter with terminal-count flag. Counts
//                enabled cycles since the last clear; terminal is high during
//                the LIMIT-th enabled cycle.
//  Ports       : clk, rst_n  - clock, async active-low reset
//                clear      - synchronous clear (priority over enable)
//                enable     - count this cycle
//                terminal   - current cycle is the LIMIT-th counted cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_watchdog #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int              c_width = $clog2(LIMIT + 1);
    localparam logic [c_width-1:0] c_last = c_width'(LIMIT - 1);

    logic [c_width-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !terminal) begin
            // Saturates at the terminal value so the flag cannot wrap away
            r_count <= r_count + 1'b1;
        end
    end

    assign terminal = enable && (r_count == c_last);

endmodule : fetch_watchdog
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Sequential instruction-fetch stage. Owns the architectural
//                PC, issues valid/ready requests to instruction memory, holds
//                the returned word until the datapath consumes it, and then
//                commits next_pc. Faults (bus error, misaligned next_pc,
//                optional timeout) are sticky until reset.
//  Ports       : clk, rst_n                 - clock, async active-low reset
//                fetch_en                   - permit a new fetch
//                next_pc                    - PC-source mux output
//                imem_req_valid/ready/addr  - memory request channel
//                imem_rsp_valid/data/err    - memory response channel
//                instr_valid/ready, instr   - datapath handoff
//                pc                         - PC of held/requested word
//                fault, fault_cause, fault_pc - sticky fault report
//  Options     : FETCH_TIMEOUT_EN - build the WAIT-state watchdog
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic [31:0] next_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_pc
);

    import mips_pkg::*;

    fetch_state_e r_state;
    fetch_state_e w_next_state;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [1:0]  r_fault_cause;
    logic [31:0] r_fault_pc;

    logic        w_pc_load;
    logic        w_instr_load;
    logic        w_fault_load;
    logic [1:0]  w_fault_cause_nxt;
    logic [31:0] w_fault_pc_nxt;
    logic        w_in_wait;
    logic        w_wd_tc;

    assign w_in_wait = (r_state == ST_WAIT);

`ifdef FETCH_TIMEOUT_EN
    fetch_watchdog #(
        .LIMIT    (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (!w_in_wait),
        .enable   (w_in_wait),
        .terminal (w_wd_tc)
    );
`else
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = TIMEOUT_CYCLES;
    assign w_wd_tc          = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and register-load decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state      = r_state;
        w_pc_load         = 1'b0;
        w_instr_load      = 1'b0;
        w_fault_load      = 1'b0;
        w_fault_cause_nxt = FC_NONE;
        w_fault_pc_nxt    = '0;

        case (r_state)
            ST_IDLE: begin
                if (fetch_en) begin
                    w_next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                // A response in the acceptance cycle is not looked at here
                if (imem_req_ready) begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response coinciding with the watchdog limit wins
                if (imem_rsp_valid) begin
                    if (imem_rsp_err) begin
                        w_next_state      = ST_FAULT;
                        w_fault_load      = 1'b1;
                        w_fault_cause_nxt = FC_BUS;
                        w_fault_pc_nxt    = r_pc;
                    end else begin
                        w_next_state = ST_HOLD;
                        w_instr_load = 1'b1;
                    end
                end else if (w_wd_tc) begin
                    w_next_state      = ST_FAULT;
                    w_fault_load      = 1'b1;
                    w_fault_cause_nxt = FC_TIMEOUT;
                    w_fault_pc_nxt    = r_pc;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    w_pc_load = 1'b1;
                    if (next_pc[1:0] != 2'b00) begin
                        w_next_state      = ST_FAULT;
                        w_fault_load      = 1'b1;
                        w_fault_cause_nxt = FC_MISALIGN;
                        w_fault_pc_nxt    = next_pc;
                    end else if (fetch_en) begin
                        w_next_state = ST_REQ;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            ST_FAULT: begin
                // Sticky: only reset leaves
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_fault_cause <= FC_NONE;
            r_fault_pc    <= '0;
        end else begin
            if (w_pc_load) begin
                r_pc <= next_pc;
            end
            if (w_instr_load) begin
                r_instr <= imem_rsp_data;
            end
            if (w_fault_load) begin
                r_fault_cause <= w_fault_cause_nxt;
                r_fault_pc    <= w_fault_pc_nxt;
            end
        end
    end

    // Outputs come only from registers or the state decode
    assign imem_req_valid = (r_state == ST_REQ);
    assign imem_addr      = r_pc;
    assign instr_valid    = (r_state == ST_HOLD);
    assign instr          = r_instr;
    assign pc             = r_pc;
    assign fault          = (r_state == ST_FAULT);
    assign fault_cause    = r_fault_cause;
    assign fault_pc       = r_fault_pc;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. A reactive memory model
//                answers requests; a behavioural model predicts outputs and
//                is compared every cycle; directed steps add literal checks.
//  Options     : FETCH_TIMEOUT_EN - expects the WAIT timeout behaviour
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TO       = 16;

    logic        clk            = 1'b0;
    logic        rst_n          = 1'b0;
    logic        fetch_en       = 1'b0;
    logic [31:0] next_pc        = 32'h0;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        imem_rsp_err   = 1'b0;
    logic        instr_ready    = 1'b0;

    logic        imem_req_valid;
    logic [31:0] imem_addr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fault_pc;

    fetch_unit #(
        .RESET_PC       (RESET_PC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .next_pc        (next_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .pc             (pc),
        .fault          (fault),
        .fault_cause    (fault_cause),
        .fault_pc       (fault_pc)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Instruction memory: answers the cycle after acceptance
    // ------------------------------------------------------------------
    int          stall_cnt   = 0;
    logic        stray       = 1'b0;
    logic [31:0] err_addr    = 32'hFFFF_FFFF;
    logic [31:0] silent_addr = 32'hFFFF_FFFF;
    int          hs_count    = 0;
    logic        pend        = 1'b0;
    logic [31:0] paddr       = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h2008_0005 : (32'hC000_0000 ^ a);
    endfunction

    always @(negedge clk) begin
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        if (!rst_n) begin
            pend           = 1'b0;
            imem_req_ready = 1'b0;
        end else begin
            if (pend) begin
                pend = 1'b0;
                if (paddr != silent_addr) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(paddr);
                    imem_rsp_err   = (paddr == err_addr);
                end
            end else if (stray) begin
                stray          = 1'b0;
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
            if (imem_req_valid && stall_cnt > 0) begin
                stall_cnt--;
                imem_req_ready = 1'b0;
            end else begin
                imem_req_ready = 1'b1;
            end
            if (imem_req_valid && imem_req_ready) begin
                pend  = 1'b1;
                paddr = imem_addr;
                hs_count++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Behavioural model: what the fetch stage is doing, as flags
    // ------------------------------------------------------------------
    logic        m_req, m_wait, m_hold, m_fault;
    logic [31:0] m_pc, m_instr, m_fpc;
    logic [1:0]  m_cause;
    int          m_wcnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_req = 0; m_wait = 0; m_hold = 0; m_fault = 0;
            m_pc = RESET_PC; m_instr = 0; m_fpc = 0; m_cause = 0; m_wcnt = 0;
        end else if (m_fault) begin
            // stays faulted
        end else if (m_hold) begin
            if (instr_ready) begin
                m_hold = 0;
                m_pc   = next_pc;
                if (next_pc[1:0] != 2'b00) begin
                    m_fault = 1; m_cause = 2'd2; m_fpc = next_pc;
                end else begin
                    m_req = fetch_en;
                end
            end
        end else if (m_wait) begin
            if (imem_rsp_valid) begin
                m_wait = 0;
                if (imem_rsp_err) begin
                    m_fault = 1; m_cause = 2'd1; m_fpc = m_pc;
                end else begin
                    m_hold = 1; m_instr = imem_rsp_data;
                end
            end else begin
                m_wcnt++;
`ifdef FETCH_TIMEOUT_EN
                if (m_wcnt == TO) begin
                    m_wait = 0; m_fault = 1; m_cause = 2'd3; m_fpc = m_pc;
                end
`endif
            end
        end else if (m_req) begin
            if (imem_req_ready) begin
                m_req = 0; m_wait = 1; m_wcnt = 0;
            end
        end else if (fetch_en) begin
            m_req = 1;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk1("req_valid", imem_req_valid, m_req);
        if (m_req) check("imem_addr", imem_addr, m_pc);
        chk1("instr_valid", instr_valid, m_hold);
        check("instr", instr, m_instr);
        check("pc", pc, m_pc);
        chk1("fault", fault, m_fault);
        check("fault_cause", 32'(fault_cause), 32'(m_cause));
        check("fault_pc", fault_pc, m_fpc);
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic wait_hold(input string name);
        int k = 0;
        while (!instr_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk1(name, instr_valid, 1'b1);
    endtask

    task automatic consume(input logic [31:0] npc);
        instr_ready = 1'b1;
        next_pc     = npc;
        @(negedge clk);
        instr_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk1("areset_fault", fault, 1'b0);
        check("areset_cause", 32'(fault_cause), 32'h0);
        check("areset_pc", pc, RESET_PC);
        @(negedge clk);
    endtask

    int hs0;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pc", pc, RESET_PC);
        check("rst_instr", instr, 32'h0);
        chk1("rst_fault", fault, 1'b0);
        chk1("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_fault_pc", fault_pc, 32'h0);

        // 1: zero-wait fetch, 3-cycle turnaround
        rst_n    = 1'b1;
        fetch_en = 1'b1;
        @(negedge clk);
        chk1("t1_req_valid", imem_req_valid, 1'b1);
        check("t1_addr", imem_addr, 32'h0);
        @(negedge clk);
        chk1("t1_wait_idle_bus", imem_req_valid | instr_valid, 1'b0);
        @(negedge clk);
        chk1("t1_instr_valid", instr_valid, 1'b1);
        check("t1_instr", instr, 32'h2008_0005);
        check("t1_pc", pc, 32'h0);
        hs0       = hs_count;
        stall_cnt = 5;
        consume(32'h4);
        chk1("t1_next_req", imem_req_valid, 1'b1);
        check("t1_next_addr", imem_addr, 32'h4);

        // 2: ready held low 5 cycles
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk1("t2_req_held", imem_req_valid, 1'b1);
            check("t2_addr_held", imem_addr, 32'h4);
        end
        wait_hold("t2_hold_reached");
        check("t2_one_accept", hs_count, hs0 + 1);
        check("t2_instr", instr, 32'hC000_0004);

        // 3: branch redirect then misaligned target
        consume(32'h8);
        wait_hold("t3_hold8");
        check("t3_pc8", pc, 32'h8);
        consume(32'h40);
        check("t3_redirect_addr", imem_addr, 32'h40);
        wait_hold("t3_hold40");
        check("t3_instr40", instr, 32'hC000_0040);
        consume(32'h42);
        chk1("t3_fault", fault, 1'b1);
        check("t3_cause", 32'(fault_cause), 32'h2);
        check("t3_fault_pc", fault_pc, 32'h42);
        hs0 = hs_count;
        repeat (5) begin
            @(negedge clk);
            chk1("t3_no_req", imem_req_valid, 1'b0);
        end
        check("t3_no_accept", hs_count, hs0);

        // 4: bus error at 0x100, sticky, cleared by reset
        do_reset();
        err_addr = 32'h100;
        rst_n    = 1'b1;
        fetch_en = 1'b1;
        wait_hold("t4_hold0");
        consume(32'h100);
        for (int k = 0; k < 20 && !fault; k++) @(negedge clk);
        chk1("t4_fault", fault, 1'b1);
        check("t4_cause", 32'(fault_cause), 32'h1);
        check("t4_fault_pc", fault_pc, 32'h100);
        for (int i = 0; i < 10; i++) begin
            fetch_en    = i[0];
            instr_ready = 1'b1;
            next_pc     = 32'(i) << 2;
            stray       = (i == 3);
            @(negedge clk);
            chk1("t4_sticky", fault, 1'b1);
            check("t4_sticky_cause", 32'(fault_cause), 32'h1);
        end
        instr_ready = 1'b0;
        stray       = 1'b0;
        err_addr    = 32'hFFFF_FFFF;
        do_reset();

        // 5: stall in HOLD, stray response, fetch_en drop in REQ
        rst_n    = 1'b1;
        fetch_en = 1'b1;
        @(negedge clk);
        fetch_en = 1'b0;
        wait_hold("t5_hold");
        hs0 = hs_count;
        for (int i = 0; i < 4; i++) begin
            stray = (i == 1);
            @(negedge clk);
            chk1("t5_still_valid", instr_valid, 1'b1);
            check("t5_instr_stable", instr, 32'h2008_0005);
            check("t5_pc_stable", pc, 32'h0);
            chk1("t5_no_req", imem_req_valid, 1'b0);
        end
        check("t5_no_accept", hs_count, hs0);
        consume(32'h20);
        repeat (3) begin
            chk1("t5_parked", imem_req_valid | instr_valid, 1'b0);
            @(negedge clk);
        end
        check("t5_pc_committed", pc, 32'h20);

        // 6: memory never answers address 0x20
        silent_addr = 32'h20;
        fetch_en    = 1'b1;
        @(negedge clk);
        check("t6_addr", imem_addr, 32'h20);
        fetch_en = 1'b0;
        @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            chk1("t6_no_early_fault", fault, 1'b0);
            @(negedge clk);
        end
        chk1("t6_wait16_no_fault", fault, 1'b0);
        @(negedge clk);
        chk1("t6_timeout_fault", fault, 1'b1);
        check("t6_cause", 32'(fault_cause), 32'h3);
        check("t6_fault_pc", fault_pc, 32'h20);
`else
        repeat (100) @(negedge clk);
        chk1("t6_no_fault", fault, 1'b0);
        chk1("t6_still_waiting", imem_req_valid | instr_valid, 1'b0);
        check("t6_pc", pc, 32'h20);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Sequential instruction-fetch stage of the MIPS monocycle core.
- Owns the architectural PC register and issues valid/ready requests to instruction memory.
- Holds the returned instruction until the datapath consumes it.
- Commits the next PC on consume; the next PC comes from the datapath's 4:1 PC-source mux (PC+4 / branch / jump / jr).
- Its pc output feeds the PC+4 adder and the jump-target unit (pc[31:28]).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TIMEOUT_CYCLES, 16, WAIT-state cycle limit before timeout fault (used only with FETCH_TIMEOUT_EN).

Ports:
clk  in  1  core clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
fetch_en  in  1  allows a new fetch to start from IDLE/HOLD.
next_pc  in  32  output of PC-source mux; sampled on consume.
imem_req_valid  out  1  request valid.
imem_req_ready  in  1  memory accepts request.
imem_addr  out  32  request address (= pc).
imem_rsp_valid  in  1  response valid (one-cycle pulse).
imem_rsp_data  in  32  instruction word.
imem_rsp_err  in  1  bus error, qualified by rsp_valid.
instr_valid  out  1  instr/pc valid for the datapath.
instr_ready  in  1  datapath executes instruction this cycle.
instr  out  32  held instruction word.
pc  out  32  PC of held/requested instruction.
fault  out  1  sticky fault flag.
fault_cause  out  2  00 none, 01 bus error, 10 misaligned next_pc, 11 timeout.
fault_pc  out  32  faulting address.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, instr=0, all valids 0, fault=0, fault_cause=00, fault_pc=0, watchdog=0.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- IDLE: all valids 0. If fetch_en=1, go to REQ on the next edge.
- REQ: imem_req_valid=1, imem_addr=pc.
  - valid and addr are held stable until imem_req_ready=1.
  - On ready, go to WAIT.
- WAIT: imem_req_valid=0.
  - On imem_rsp_valid with rsp_err=0: instr<=rsp_data, go to HOLD.
  - On imem_rsp_valid with rsp_err=1: fault_cause=01, fault_pc=pc, go to FAULT.
- HOLD: instr_valid=1; instr and pc are stable.
  - On instr_ready=1, pc<=next_pc.
  - If next_pc[1:0]!=0: fault_cause=10, fault_pc=next_pc, go to FAULT.
  - Else if fetch_en=1: go to REQ.
  - Else: go to IDLE.
  - instr_ready while instr_valid=0 is ignored.
- FAULT: fault=1, all valids 0. Only rst_n exits this state.
- Response outside WAIT: ignored; no state change.
- Response in the same cycle as the req handshake: ignored. The earliest legal response is the cycle after acceptance.
- Throughput with zero-wait memory: 3 cycles per instruction.
  - Edge N: accept in REQ.
  - Edge N+1: response in WAIT.
  - Cycle N+2: HOLD; consume lets REQ be visible in cycle N+3.
- fetch_en drop in REQ: the outstanding request completes (no retraction). The unit parks in IDLE after the consume.
- pc wraps modulo 2^32, with no special handling at 32'hFFFF_FFFC.
- Reset mid-transaction: everything returns to reset values immediately. A late memory response is then ignored (state is IDLE).

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - Watchdog counts cycles spent in WAIT and clears on leaving WAIT.
  - When the count reaches TIMEOUT_CYCLES with no response: fault_cause=11, fault_pc=pc, go to FAULT.
  - A response arriving in the same cycle as the limit wins; no fault is raised.
- Undefined:
  - No counter logic is built.
  - WAIT is unbounded.
  - Code 11 is never produced.

Decomposition:
- Shared package mips_pkg holds:
  - state encoding: IDLE, REQ, WAIT, HOLD, FAULT;
  - fault cause constants: FC_NONE, FC_BUS, FC_MISALIGN, FC_TIMEOUT.
- One sub-module, fetch_watchdog: clear/enable counter with terminal-count output. It is instantiated only under FETCH_TIMEOUT_EN.

Test Plan:
1. Reset release, fetch_en=1, zero-wait memory returning 32'h2008_0005:
   - imem_addr=0 while req_valid.
   - instr_valid in the 3rd cycle with instr=32'h2008_0005, pc=0.
   - After consume with next_pc=4, the next req goes to addr 4.
2. imem_req_ready held low for 5 cycles:
   - req_valid and addr stay constant for all 5 cycles.
   - Exactly one acceptance; a single instruction is delivered.
3. Branch redirect: in HOLD at pc=8, next_pc=32'h0000_0040, instr_ready=1:
   - the next req addr is 32'h40.
   - Then next_pc=32'h0000_0042 causes fault=1, fault_cause=10, fault_pc=32'h42, and no further requests.
4. rsp_err=1 on a fetch at 32'h100:
   - fault=1, fault_cause=01, fault_pc=32'h100.
   - The fault stays sticky through 10 cycles of stimulus.
   - Asserting rst_n=0 clears it and pc returns to RESET_PC.
5. instr_ready held low 4 cycles in HOLD:
   - instr and pc remain stable.
   - No new request is issued.
   - A stray rsp_valid pulse during HOLD is ignored.
6. With FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, memory never responds to addr 32'h20:
   - fault_cause=11 and fault_pc=32'h20 after 16 WAIT cycles.
   - Without the macro, the unit is still in WAIT after 100 cycles.
